weight_loader: RTL and testbench

//   Write-side companion to the synaptic weight store: accepts a stream of weight words

---
 rtl/weight_loader.sv | 233 +++++++++++++++++++++++
 tb/tb_weight_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/weight_loader.sv
// -----------------------------------------------------------------------------
// weight_loader
//
// Write-side companion to the synaptic weight store. Accepts a stream of
// weight words over a valid/ready handshake and issues one registered write
// per accepted word to consecutive addresses, starting at a programmed base.
// Used for the initial weight load and for runtime reprogramming of a region.
//
// Handshake: a word is transferred in every cycle where s_valid_i and
// s_ready_o are both high at the rising edge of clk_i. s_ready_o is a pure
// decode of the FSM state (high only in LOAD) and never depends on
// s_valid_i. The producer may hold s_valid_i low for any number of cycles.
//
// Optional feature macro: WEIGHT_LOADER_CHECKSUM_EN
//   When defined, adds exp_sum_i / chk_err_o and a running modulo-2^dataWidth
//   sum of accepted words that is compared against exp_sum_i on completion.
//
// Parameters
//   dataWidth   width of one weight word
//   AddrWidth   address MSB index (addresses are AddrWidth+1 bits)
//   numWeight   number of weight locations (last valid address numWeight-1)
//
// Ports
//   clk_i        in   clock, rising edge
//   rst_i        in   synchronous active-high reset
//   start_i      in   begin a load (sampled only in IDLE)
//   base_addr_i  in   first write address, latched on start
//   count_i      in   number of words, latched on start
//   s_valid_i    in   stream word valid
//   s_data_i     in   stream weight word
//   s_ready_o    out  loader accepts a word this cycle
//   we_o         out  weight RAM write enable (registered)
//   w_addr_o     out  weight RAM write address (registered)
//   w_data_o     out  weight RAM write data (registered)
//   busy_o       out  high in LOAD
//   done_o       out  one-cycle pulse when a load completes or aborts
//   err_o        out  sticky range error, cleared by the next accepted start
//   state_o      out  FSM state for debug (0=IDLE, 1=LOAD, 2=DONE)
//   exp_sum_i    in   expected checksum, latched on start (checksum build)
//   chk_err_o    out  checksum mismatch, valid from DONE (checksum build)
// -----------------------------------------------------------------------------
module weight_loader #(
    parameter int dataWidth = 16,
    parameter int AddrWidth = 10,
    parameter int numWeight = 961
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [AddrWidth:0]   base_addr_i,
    input  logic [AddrWidth:0]   count_i,
    input  logic                 s_valid_i,
    input  logic [dataWidth-1:0] s_data_i,
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    input  logic [dataWidth-1:0] exp_sum_i,
    output logic                 chk_err_o,
`endif
    output logic                 s_ready_o,
    output logic                 we_o,
    output logic [AddrWidth:0]   w_addr_o,
    output logic [dataWidth-1:0] w_data_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [1:0]           state_o
);

    // Range check is evaluated one bit wider than an address so the sum of
    // base and count can never wrap around.
    localparam int SumW = AddrWidth + 2;
    localparam logic [SumW-1:0]  Limit = SumW'(numWeight);
    localparam logic [AddrWidth:0] CntOne = (AddrWidth + 1)'(1);
    localparam logic [AddrWidth:0] CntZero = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [AddrWidth:0]   addr_q;
    logic [AddrWidth:0]   remaining_q;
    logic                 we_q;
    logic [AddrWidth:0]   w_addr_q;
    logic [dataWidth-1:0] w_data_q;
    logic                 err_q;

    logic                 start_take;
    logic                 count_zero;
    logic                 range_bad;
    logic                 accept;
    logic                 last_accept;
    logic [SumW-1:0]      range_sum;

    // ------------------------------------------------------------------
    // Next-state and handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        start_take  = 1'b0;
        accept      = 1'b0;
        last_accept = 1'b0;
        range_sum   = {1'b0, base_addr_i} + {1'b0, count_i};
        count_zero  = (count_i == CntZero);
        range_bad   = (range_sum > Limit);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    start_take = 1'b1;
                    // Empty or out-of-range requests finish without writes.
                    if (count_zero || range_bad) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                accept = s_valid_i;
                if (s_valid_i && (remaining_q == CntOne)) begin
                    last_accept = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Address / count bookkeeping and registered write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q      <= '0;
            remaining_q <= '0;
            we_q        <= 1'b0;
            w_addr_q    <= '0;
            w_data_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            // Write enable follows the accept by exactly one cycle.
            we_q <= accept;

            if (start_take) begin
                addr_q      <= base_addr_i;
                remaining_q <= count_i;
                // A zero-length request is never flagged, whatever the base.
                err_q       <= !count_zero && range_bad;
            end

            if (accept) begin
                w_addr_q    <= addr_q;
                w_data_q    <= s_data_i;
                remaining_q <= remaining_q - CntOne;
                // Hold the address on the final word so addr_q stays inside
                // the weight region even when the load ends at its top.
                if (!last_accept) begin
                    addr_q <= addr_q + CntOne;
                end
            end
        end
    end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    // ------------------------------------------------------------------
    // Checksum of accepted words, modulo 2^dataWidth
    // ------------------------------------------------------------------
    logic [dataWidth-1:0] sum_q;
    logic [dataWidth-1:0] exp_sum_q;
    logic [dataWidth-1:0] sum_next;
    logic                 chk_err_q;

    assign sum_next = sum_q + s_data_i;

    // The compare is resolved on the edge that enters DONE, so chk_err_o is
    // already valid alongside done_o and then holds until the next start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_q     <= '0;
            exp_sum_q <= '0;
            chk_err_q <= 1'b0;
        end else begin
            if (start_take) begin
                sum_q     <= '0;
                exp_sum_q <= exp_sum_i;
                if (count_zero || range_bad) begin
                    chk_err_q <= (exp_sum_i != '0);
                end else begin
                    chk_err_q <= 1'b0;
                end
            end
            if (accept) begin
                sum_q <= sum_next;
                if (last_accept) begin
                    chk_err_q <= (sum_next != exp_sum_q);
                end
            end
        end
    end

    assign chk_err_o = chk_err_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_ready_o = (state_q == LOAD);
    assign busy_o    = (state_q == LOAD);
    assign done_o    = (state_q == DONE);
    assign we_o      = we_q;
    assign w_addr_o  = w_addr_q;
    assign w_data_o  = w_data_q;
    assign err_o     = err_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_weight_loader.sv
module tb_weight_loader;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int NW = 961;
  localparam int QW = AW + 1 + DW;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [AW:0]   base_addr_i = '0;
  logic [AW:0]   count_i = '0;
  logic          s_valid_i = 1'b0;
  logic [DW-1:0] s_data_i = '0;
  logic          s_ready_o;
  logic          we_o;
  logic [AW:0]   w_addr_o;
  logic [DW-1:0] w_data_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [1:0]    state_o;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [DW-1:0] exp_sum_i = '0;
  logic          chk_err_o;
`endif

  weight_loader #(
    .dataWidth(DW),
    .AddrWidth(AW),
    .numWeight(NW)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .start_i(start_i),
    .base_addr_i(base_addr_i),
    .count_i(count_i),
    .s_valid_i(s_valid_i),
    .s_data_i(s_data_i),
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    .exp_sum_i(exp_sum_i),
    .chk_err_o(chk_err_o),
`endif
    .s_ready_o(s_ready_o),
    .we_o(we_o),
    .w_addr_o(w_addr_o),
    .w_data_o(w_data_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o),
    .state_o(state_o)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [QW-1:0] exp_q[$];
  logic          acc_pend = 1'b0;
  logic [AW:0]   model_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then check the write port against
  // what the previous cycle's accepted word (if any) should have produced.
  task automatic tick();
    logic [QW-1:0] e;
    @(negedge clk_i);
    chk("we", {31'b0, we_o}, {31'b0, acc_pend});
    if (acc_pend) begin
      e = exp_q.pop_front();
      chk("wr_addr_data", {5'b0, w_addr_o, w_data_o}, {5'b0, e});
    end
    acc_pend = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start(input int base, input int cnt);
    start_i = 1'b1;
    base_addr_i = (AW + 1)'(base);
    count_i = (AW + 1)'(cnt);
    model_addr = (AW + 1)'(base);
    tick();
    start_i = 1'b0;
  endtask

  task automatic drive_word(input logic v, input logic [DW-1:0] d);
    s_valid_i = v;
    s_data_i = d;
    chk("ready_in_load", {31'b0, s_ready_o}, 32'd1);
    chk("busy_in_load", {31'b0, busy_o}, 32'd1);
    if (v) begin
      exp_q.push_back({model_addr, d});
      model_addr = model_addr + 1'b1;
      acc_pend = 1'b1;
    end
    tick();
    s_valid_i = 1'b0;
  endtask

  task automatic check_done(input logic e);
    chk("done_pulse", {31'b0, done_o}, 32'd1);
    chk("done_err", {31'b0, err_o}, {31'b0, e});
    chk("done_ready", {31'b0, s_ready_o}, 32'd0);
    chk("done_busy", {31'b0, busy_o}, 32'd0);
    chk("done_state", {30'b0, state_o}, 32'd2);
    tick();
    chk("after_done", {31'b0, done_o}, 32'd0);
    chk("after_state", {30'b0, state_o}, 32'd0);
    chk("after_err", {31'b0, err_o}, {31'b0, e});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [DW-1:0] d;
    logic [6:0] pat;

    // reset
    rst_i = 1'b1;
    tick(); tick(); tick();
    chk("rst_state", {30'b0, state_o}, 32'd0);
    chk("rst_ready", {31'b0, s_ready_o}, 32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    chk("rst_err", {31'b0, err_o}, 32'd0);
    chk("rst_addr", {21'b0, w_addr_o}, 32'd0);
    chk("rst_data", {16'b0, w_data_o}, 32'd0);
    rst_i = 1'b0;
    tick();

    // 1: three words back to back from address 0
    do_start(0, 3);
    drive_word(1'b1, 16'h0011);
    drive_word(1'b1, 16'h0022);
    drive_word(1'b1, 16'h0033);
    check_done(1'b0);

    // 2: bubbles 1,0,0,1,1,0,1 from base 100 (first IDLE cycle after DONE)
    do_start(100, 4);
    pat = 7'b1011001;
    for (int i = 0; i < 7; i++) begin
      d = DW'($urandom_range(0, 65535));
      drive_word(pat[i], d);
    end
    check_done(1'b0);

    // 3: overflow 960+2 > 961, abort with no writes
    do_start(960, 2);
    check_done(1'b1);
    tick();
    chk("err_sticky", {31'b0, err_o}, 32'd1);
    chk("ovf_ready", {31'b0, s_ready_o}, 32'd0);

    // boundary: 959+2 == 961 is legal, ends at the top address; err clears
    do_start(959, 2);
    chk("err_cleared", {31'b0, err_o}, 32'd0);
    drive_word(1'b1, 16'hA5A5);
    drive_word(1'b1, 16'h5A5A);
    check_done(1'b0);

    // 4: zero count, then a start held high through a whole load
    do_start(5, 0);
    check_done(1'b0);
    do_start(5, 2);
    start_i = 1'b1;
    base_addr_i = 11'd300;
    count_i = 11'd7;
    drive_word(1'b1, 16'h1234);
    start_i = 1'b1;
    drive_word(1'b1, 16'h4321);
    check_done(1'b0);
    start_i = 1'b0;
    tick();
    chk("ignored_start_state", {30'b0, state_o}, 32'd0);
    chk("ignored_start_busy", {31'b0, busy_o}, 32'd0);

    // 5: reset after two of five words
    do_start(10, 5);
    drive_word(1'b1, 16'h0BEE);
    drive_word(1'b1, 16'h0CAF);
    rst_i = 1'b1;
    s_valid_i = 1'b1;
    s_data_i = 16'hDEAD;
    tick();
    chk("midrst_state", {30'b0, state_o}, 32'd0);
    chk("midrst_ready", {31'b0, s_ready_o}, 32'd0);
    chk("midrst_busy", {31'b0, busy_o}, 32'd0);
    chk("midrst_done", {31'b0, done_o}, 32'd0);
    chk("midrst_err", {31'b0, err_o}, 32'd0);
    chk("midrst_addr", {21'b0, w_addr_o}, 32'd0);
    chk("midrst_data", {16'b0, w_data_o}, 32'd0);
    rst_i = 1'b0;
    s_valid_i = 1'b0;
    tick();
    chk("postrst_done", {31'b0, done_o}, 32'd0);
    chk("postrst_state", {30'b0, state_o}, 32'd0);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    // 6: checksum wraps modulo 2^16
    exp_sum_i = 16'h0001;
    do_start(0, 2);
    drive_word(1'b1, 16'hFFFF);
    drive_word(1'b1, 16'h0002);
    chk("chk_match", {31'b0, chk_err_o}, 32'd0);
    check_done(1'b0);
    exp_sum_i = 16'h0002;
    do_start(0, 2);
    drive_word(1'b1, 16'hFFFF);
    drive_word(1'b1, 16'h0002);
    chk("chk_mismatch", {31'b0, chk_err_o}, 32'd1);
    check_done(1'b0);
    tick();
    chk("chk_hold", {31'b0, chk_err_o}, 32'd1);
`endif

    tick();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
